pci_rr_arbiter: RTL

- Central PCI bus arbiter with round-robin fairness among NUM_MASTERS initiators.
- Adds bus parking, a one-cycle grant turnaround gap, a grant-without-FRAME timeout and grant removal while busy when others are waiting.
- Sits beside the bus-monitor logic. Samples active-low Req_n, Frame_n and Irdy_n, and drives active-low Gnt_n to each master.

---
 rtl/pci_arb_pkg.sv | 28 ++
 rtl/pci_rr_arbiter_if.sv | 34 +++
 rtl/pci_rr_picker.sv | 37 +++
 rtl/pci_rr_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pci_arb_pkg.sv
// ============================================================================
// Module      : pci_arb_pkg
// Description : Shared types and defaults for the PCI round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pci_arb_pkg;

   localparam int DEF_NUM_MASTERS = 3;
   localparam int DEF_PARK_MASTER = 0;
   localparam int DEF_GNT_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SWITCH = 2'd1,
      ST_GRANT  = 2'd2,
      ST_BUSY   = 2'd3
   } arb_state_e;

   // Width of a master index; never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pci_rr_arbiter_if.sv
// ============================================================================
// Module      : pci_rr_arbiter_if
// Description : PCI request/grant and bus-state signals seen by the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pci_rr_arbiter_if
   import pci_arb_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS
);
   localparam int IDX_W = idx_width(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] Req_n;
   logic                   Frame_n;
   logic                   Irdy_n;
   logic [NUM_MASTERS-1:0] Gnt_n;
   logic [IDX_W-1:0]       Owner;
   logic                   Bus_busy;

   modport master (
      input  Req_n, Frame_n, Irdy_n,
      output Gnt_n, Owner, Bus_busy
   );

   modport slave (
      output Req_n, Frame_n, Irdy_n,
      input  Gnt_n, Owner, Bus_busy
   );

endinterface

`default_nettype wire

// File: rtl/pci_rr_picker.sv
// ============================================================================
// Module      : pci_rr_picker
// Description : Combinational round-robin search starting just above ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pci_rr_picker
   import pci_arb_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   localparam int IDX_W      = idx_width(NUM_MASTERS)
) (
   input  wire logic [NUM_MASTERS-1:0] req,
   input  wire logic [IDX_W-1:0]       ptr,
   output logic      [IDX_W-1:0]       winner,
   output logic                        valid
);

   always_comb begin
      int idx;
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      // ptr itself is visited last, giving the previous owner lowest priority.
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = (int'(ptr) + i) % NUM_MASTERS;
         if (!valid && req[idx[IDX_W-1:0]]) begin
            valid  = 1'b1;
            winner = idx[IDX_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/pci_rr_arbiter.sv
// ============================================================================
// Module      : pci_rr_arbiter
// Description : Central PCI round-robin arbiter with parking, turnaround gap,
//               idle-grant timeout and grant removal while busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pci_rr_arbiter
   import pci_arb_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int PARK_MASTER = DEF_PARK_MASTER,
   parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT
) (
   input  wire logic         Clk,
   input  wire logic         Rst_n,
   pci_rr_arbiter_if.master  bus
);

   localparam int IDX_W = idx_width(NUM_MASTERS);
   localparam int TMR_W = $clog2(GNT_TIMEOUT + 1);

   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(GNT_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(GNT_TIMEOUT);
   localparam logic [IDX_W-1:0] PARK_IDX  = IDX_W'(PARK_MASTER);
   localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_MASTERS - 1);

   arb_state_e             state_q,    state_d;
   logic [NUM_MASTERS-1:0] gnt_n_q,    gnt_n_d;
   logic [IDX_W-1:0]       owner_q,    owner_d;
   logic [IDX_W-1:0]       ptr_q,      ptr_d;
   logic [IDX_W-1:0]       winner_q,   winner_d;
   logic [TMR_W-1:0]       timer_q,    timer_d;
   logic                   bus_busy_q, bus_busy_d;

   logic [NUM_MASTERS-1:0] w_req;
   logic [NUM_MASTERS-1:0] w_owner_mask;
   logic [IDX_W-1:0]       w_winner;
   logic                   w_valid;
   logic                   w_bus_idle;
   logic                   w_gnt_low;

   function automatic logic [NUM_MASTERS-1:0] gnt_for(input logic [IDX_W-1:0] idx);
      logic [NUM_MASTERS-1:0] v;
      v      = '1;
      v[idx] = 1'b0;
      return v;
   endfunction

   assign w_req        = ~bus.Req_n;
   assign w_owner_mask = ~gnt_for(owner_q);
   assign w_bus_idle   = bus.Frame_n & bus.Irdy_n;
   assign w_gnt_low    = ~&gnt_n_q;

   pci_rr_picker #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_picker (
      .req    (w_req),
      .ptr    (ptr_q),
      .winner (w_winner),
      .valid  (w_valid)
   );

   always_comb begin
      state_d    = state_q;
      gnt_n_d    = gnt_n_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      winner_d   = winner_q;
      timer_d    = timer_q;
      bus_busy_d = ~w_bus_idle;

      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (!w_bus_idle) begin
               // A granted (typically parked) master started a cycle.
               if (w_gnt_low && !bus.Frame_n) begin
                  state_d = ST_BUSY;
                  ptr_d   = owner_q;
               end
            end else if (w_valid) begin
               if (!w_gnt_low || !gnt_n_q[w_winner]) begin
                  gnt_n_d = gnt_for(w_winner);
                  owner_d = w_winner;
                  state_d = ST_GRANT;
               end else begin
                  gnt_n_d  = '1;
                  winner_d = w_winner;
                  state_d  = ST_SWITCH;
               end
            end else if (!w_gnt_low) begin
               gnt_n_d = gnt_for(PARK_IDX);
               owner_d = PARK_IDX;
            end
         end

         ST_SWITCH: begin
            gnt_n_d = gnt_for(winner_q);
            owner_d = winner_q;
            timer_d = '0;
            state_d = ST_GRANT;
         end

         ST_GRANT: begin
            if (timer_q != TMR_MAX) begin
               timer_d = timer_q + TMR_W'(1);
            end
            if (!bus.Frame_n) begin
               state_d = ST_BUSY;
               ptr_d   = owner_q;
               timer_d = '0;
            end else if (bus.Req_n[owner_q]) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else if (timer_q >= TMR_LAST) begin
               // Owner squandered its grant: drop it and push it to the back.
               ptr_d   = owner_q;
               gnt_n_d = '1;
               timer_d = '0;
               state_d = ST_IDLE;
            end
         end

         ST_BUSY: begin
            timer_d = '0;
            if (|(w_req & ~w_owner_mask)) begin
               gnt_n_d = '1;
            end
            if (w_bus_idle) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            gnt_n_d = '1;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= ST_IDLE;
         gnt_n_q    <= '1;
         owner_q    <= '0;
         ptr_q      <= PTR_RESET;
         winner_q   <= '0;
         timer_q    <= '0;
         bus_busy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_n_q    <= gnt_n_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         winner_q   <= winner_d;
         timer_q    <= timer_d;
         bus_busy_q <= bus_busy_d;
      end
   end

   assign bus.Gnt_n    = gnt_n_q;
   assign bus.Owner    = owner_q;
   assign bus.Bus_busy = bus_busy_q;

endmodule

`default_nettype wire
